branch_checkpoint_table: RTL
============================

# branch_checkpoint_table

Four-entry table, one entry per branch tag, holding the recovery snapshot taken when a branch dispatches, plus the ancestry (branch mask) of every in-flight branch. Sits between the execute-stage branch units and `branch_recovery_controller`. Consumes the dispatching branch's marker and mask from that controller, and the branch resolutions from execute. Produces the registered `cl_enable_k`/`cl_position_k` tag-free strobes that controller consumes, plus the rollback snapshot and squash mask on a mispredict.

## Interface
- `ROB_IDX_W`, default 5: width of the stored ROB tail pointer.
- `FL_IDX_W`, default 5: width of the stored physical-register freelist head.

Ports (clock and reset first):
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `alloc_marker`  in  3  tag of the branch dispatching this cycle; `` `BR_MARKER_EMPTY `` (3'b100) means no branch.
- `alloc_bmask`  in  4  mask of older in-flight tags for the dispatching branch. May include its own bit, which is ignored.
- `alloc_rob_tail`  in  ROB_IDX_W  ROB tail to restore if this branch mispredicts.
- `alloc_fl_head`  in  FL_IDX_W  freelist head to restore if this branch mispredicts.
- `ex_br_valid_1`, `ex_br_valid_2`  in  1  branch resolution valid, ports 1 and 2.
- `ex_br_tag_1`, `ex_br_tag_2`  in  2  tag being resolved.
- `ex_br_mispred_1`, `ex_br_mispred_2`  in  1  resolution was a mispredict.
- `cl_enable_1` .. `cl_enable_4`  out  1  registered; `cl_enable_k` high frees tag k-1.
- `cl_position_1` .. `cl_position_4`  out  2  constant k-1.
- `resolved_mask`  out  4  registered; tags that resolved correctly, for bmask-bit clearing downstream.
- `recover_valid`  out  1  registered one-cycle mispredict strobe.
- `recover_squash_mask`  out  4  registered; the mispredicted tag plus every younger tag.
- `recover_rob_tail`  out  ROB_IDX_W  registered snapshot of the winning mispredict.
- `recover_fl_head`  out  FL_IDX_W  registered snapshot of the winning mispredict.
- `protocol_err`  out  1  sticky; cleared only by reset.

## Operation
- Per-entry state: `valid`, `mask[3:0]` (older tags; own bit forced 0), `rob_tail`, `fl_head`.
- Allocate: when `alloc_marker[2]==0`, write entry `alloc_marker[1:0]` and set `valid`.
  - If that entry is already valid: overwrite it and set `protocol_err`.
- Correct resolution of tag t:
  - Clear `valid[t]`.
  - Clear bit t in every stored mask, including the mask being allocated this cycle.
  - Set `resolved_mask[t]` and `cl_enable_(t+1)`.
- Resolution of an invalid tag: ignored; sets `protocol_err`.
- Age order: tag a is older than tag b iff `mask[b][a]`.
- Mispredict winner:
  - If both ports mispredict, the older tag wins; the other tag is in the winner's squash set anyway.
  - Equal tags on both ports: port 1 wins, and the request is treated as one resolution.
- Squash set S is the winner tag w, plus every valid entry whose mask has bit w, plus the allocating branch this cycle (its mask contains w by construction).
  - Clear `valid` for all of S; drop the same-cycle allocation.
  - Set `cl_enable` for every tag in S.
  - `recover_squash_mask` = S.
  - `recover_rob_tail` and `recover_fl_head` come from entry w.
- Same cycle, one correct and one mispredict resolution:
  - If the correct tag is not in S: it resolves normally and appears in `resolved_mask` and `cl_enable`.
  - If it is in S: it is squashed only and is not in `resolved_mask`.
- A tag freed or squashed at edge N may be reallocated from cycle N+1 onward.

## Timing
- Resolution sampled at edge N. All outputs (`cl_*`, `resolved_mask`, `recover_*`) are valid during cycle N+1 for exactly one cycle, then return to 0.
- Table state is updated at the same edge N, so a lookup in cycle N+1 already reflects the resolution.
- Allocation latency: one cycle. An entry allocated at edge N can be resolved from cycle N+1.
- Reset (asynchronous, any time, including during a `recover_valid` cycle):
  - All `valid` cleared; all outputs 0; `protocol_err` 0; `cl_position_k` = k-1.
  - Stored snapshot fields are don't-care after reset.
- No backpressure: up to two resolutions and one allocation are accepted every cycle.

## Test plan
- Reset, then allocate tag 2 (rob_tail 7, fl_head 3) and resolve it correct next cycle -> cycle after: `cl_enable_3`=1, `resolved_mask`=4'b0100, `recover_valid`=0; all zero the cycle after that.
- Allocate tags 0, 1 (mask 0001), 3 (mask 0011) on consecutive cycles; mispredict tag 1 -> `recover_valid`=1, `recover_squash_mask`=4'b1010, snapshot equals tag 1's; `cl_enable_2`=`cl_enable_4`=1; tag 0 stays valid.
- Tags 0 and 1 valid (1 younger); port 1 mispredicts 1 and port 2 mispredicts 0 in the same cycle -> winner 0; squash mask 0011; snapshot from tag 0.
- Mispredict tag 0 in the same cycle that tag 2 is allocated with mask 0001 -> squash mask includes bit 2; tag 2 is not valid afterwards.
- Tag 0 correct and tag 1 (younger) allocated with mask 0001 in the same cycle -> tag 1's stored mask becomes 0000; a later mispredict of tag 1 squashes only tag 1.
- Resolve an unallocated tag, then assert `reset` low mid-cycle -> `protocol_err` is 1 before reset and 0 immediately (asynchronously) after; all outputs 0.

Source files
------------

// File: rtl/branch_checkpoint_table.sv
// Per-tag branch checkpoint table: snapshot + ancestry mask, resolution and mispredict squash.
// Outputs registered, one cycle after the resolving edge; no backpressure (2 resolves + 1 alloc per cycle).
module branch_checkpoint_table #(
  parameter int ROB_IDX_W = 5,
  parameter int FL_IDX_W  = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0]           alloc_marker,
  input  logic [3:0]           alloc_bmask,
  input  logic [ROB_IDX_W-1:0] alloc_rob_tail,
  input  logic [FL_IDX_W-1:0]  alloc_fl_head,
  input  logic                 ex_br_valid_1,
  input  logic                 ex_br_valid_2,
  input  logic [1:0]           ex_br_tag_1,
  input  logic [1:0]           ex_br_tag_2,
  input  logic                 ex_br_mispred_1,
  input  logic                 ex_br_mispred_2,
  output logic                 cl_enable_1,
  output logic                 cl_enable_2,
  output logic                 cl_enable_3,
  output logic                 cl_enable_4,
  output logic [1:0]           cl_position_1,
  output logic [1:0]           cl_position_2,
  output logic [1:0]           cl_position_3,
  output logic [1:0]           cl_position_4,
  output logic [3:0]           resolved_mask,
  output logic                 recover_valid,
  output logic [3:0]           recover_squash_mask,
  output logic [ROB_IDX_W-1:0] recover_rob_tail,
  output logic [FL_IDX_W-1:0]  recover_fl_head,
  output logic                 protocol_err
);

  logic [3:0]           valid;
  logic [3:0]           mask     [4];
  logic [ROB_IDX_W-1:0] rob_tail [4];
  logic [FL_IDX_W-1:0]  fl_head  [4];

  logic [3:0] cl_enable;

  logic       alloc_en;
  logic [1:0] alloc_tag;
  logic       p2_en;
  logic       hit_1, hit_2, mis_1, mis_2;
  logic       recover;
  logic [1:0] win;
  logic [3:0] squash, good, freed;
  logic [3:0] valid_nxt;
  logic [3:0] alloc_mask;
  logic       err;

  assign alloc_en  = !alloc_marker[2];
  assign alloc_tag = alloc_marker[1:0];
  // Same tag on both ports collapses to the port-1 request.
  assign p2_en = ex_br_valid_2 && !(ex_br_valid_1 && (ex_br_tag_1 == ex_br_tag_2));
  assign hit_1 = ex_br_valid_1 && valid[ex_br_tag_1];
  assign hit_2 = p2_en && valid[ex_br_tag_2];
  assign mis_1 = hit_1 && ex_br_mispred_1;
  assign mis_2 = hit_2 && ex_br_mispred_2;

  always_comb begin
    recover = mis_1 || mis_2;
    win     = ex_br_tag_1;
    if (mis_2 && (!mis_1 || mask[ex_br_tag_1][ex_br_tag_2]))
      win = ex_br_tag_2;

    squash = 4'b0000;
    if (recover) begin
      squash[win] = 1'b1;
      for (int i = 0; i < 4; i++)
        if (valid[i] && mask[i][win])
          squash[i] = 1'b1;
      if (alloc_en)
        squash[alloc_tag] = 1'b1;
    end

    good = 4'b0000;
    if (hit_1 && !ex_br_mispred_1) good[ex_br_tag_1] = 1'b1;
    if (hit_2 && !ex_br_mispred_2) good[ex_br_tag_2] = 1'b1;
    good  = good & ~squash;
    freed = good | squash;

    valid_nxt = valid & ~freed;
    if (alloc_en && !recover)
      valid_nxt[alloc_tag] = 1'b1;

    alloc_mask = alloc_bmask & ~freed;
    alloc_mask[alloc_tag] = 1'b0;

    err = (alloc_en && valid[alloc_tag])
       || (ex_br_valid_1 && !valid[ex_br_tag_1])
       || (p2_en && !valid[ex_br_tag_2]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid               <= 4'b0000;
      for (int i = 0; i < 4; i++)
        mask[i]           <= 4'b0000;
      cl_enable           <= 4'b0000;
      resolved_mask       <= 4'b0000;
      recover_valid       <= 1'b0;
      recover_squash_mask <= 4'b0000;
      recover_rob_tail    <= '0;
      recover_fl_head     <= '0;
      protocol_err        <= 1'b0;
    end else begin
      valid <= valid_nxt;
      for (int i = 0; i < 4; i++)
        mask[i] <= mask[i] & ~freed;
      if (alloc_en && !recover)
        mask[alloc_tag] <= alloc_mask;
      cl_enable           <= freed;
      resolved_mask       <= good;
      recover_valid       <= recover;
      recover_squash_mask <= squash;
      recover_rob_tail    <= recover ? rob_tail[win] : '0;
      recover_fl_head     <= recover ? fl_head[win]  : '0;
      if (err)
        protocol_err <= 1'b1;
    end
  end

  // Snapshot payload needs no reset: it is only read while its valid bit is set.
  always_ff @(posedge clock) begin
    if (alloc_en && !recover) begin
      rob_tail[alloc_tag] <= alloc_rob_tail;
      fl_head[alloc_tag]  <= alloc_fl_head;
    end
  end

  assign cl_enable_1   = cl_enable[0];
  assign cl_enable_2   = cl_enable[1];
  assign cl_enable_3   = cl_enable[2];
  assign cl_enable_4   = cl_enable[3];
  assign cl_position_1 = 2'd0;
  assign cl_position_2 = 2'd1;
  assign cl_position_3 = 2'd2;
  assign cl_position_4 = 2'd3;

endmodule
